// File: rtl/bus_pkg.sv
// Bus-wide constants and the copy engine's state encoding, shared by bus
// initiators on the system data bus.
package bus_pkg;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } dma_state_t;

endpackage

// File: rtl/bus_dma.sv
// Second bus master that copies a block of words from src to dst, one read
// followed by one write per word, in ascending address order.
module bus_dma #(
  parameter int ADDR_W = bus_pkg::ADDR_W,
  parameter int DATA_W = bus_pkg::DATA_W,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              bus_req,
  input  logic              bus_grant,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              read,
  output logic              write,
  inout  logic [DATA_W-1:0] bus_data
);

  import bus_pkg::*;

  dma_state_t        state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] hold_q, hold_d;

  logic [LEN_W-1:0]  idx_inc;
  logic [ADDR_W-1:0] idx_ext;

  assign idx_inc = idx_q + LEN_W'(1);
  assign idx_ext = ADDR_W'(idx_q);

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            src_d   = src_addr;
            dst_d   = dst_addr;
            len_d   = len;
            idx_d   = '0;
            state_d = READ;
          end else begin
            state_d = DONE;
          end
        end
      end
      READ: begin
        // Responder data is combinational; capture it at the end of the granted read cycle.
        if (bus_grant) begin
          hold_d  = bus_data;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (bus_grant) begin
          idx_d   = idx_inc;
          state_d = (idx_inc == len_q) ? DONE : READ;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    busy     = (state_q == READ) || (state_q == WRITE);
    done     = (state_q == DONE);
    bus_req  = busy;
    read     = (state_q == READ) && bus_grant;
    write    = (state_q == WRITE) && bus_grant;
    bus_addr = '0;
    if (read) begin
      bus_addr = src_q + idx_ext;
    end else if (write) begin
      bus_addr = dst_q + idx_ext;
    end
  end

  assign bus_data = write ? hold_q : 'z;

endmodule

// File: tb/tb_bus_dma.sv
// Directed bench for bus_dma: a small word memory acts as the bus responder
// and each copy scenario is checked against hand-computed cycle counts and data.
module tb_bus_dma;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [19:0] src_addr;
  logic [19:0] dst_addr;
  logic [15:0] len;
  logic        busy;
  logic        done;
  logic        bus_req;
  logic        grant;
  logic [19:0] bus_addr;
  logic        read;
  logic        write;
  tri   [15:0] bus_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mem [0:4095];
  logic        tb_we = 1'b0;
  logic [11:0] tb_wa = '0;
  logic [15:0] tb_wd = '0;
  logic [15:0] z16 = 'z;

  int          done_cyc, done_cnt, busy_cnt, overlap, stall_strobes, req_bad, wr_cnt;
  logic [19:0] rd_q [$];

  always #5 clk = ~clk;

  bus_dma #(.ADDR_W(20), .DATA_W(16), .LEN_W(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .bus_req  (bus_req),
    .bus_grant(grant),
    .bus_addr (bus_addr),
    .read     (read),
    .write    (write),
    .bus_data (bus_data)
  );

  // Responder: asynchronous read, write on the clock edge; bench preload port shares the write path.
  assign bus_data = read ? mem[bus_addr[11:0]] : 16'bz;

  always @(posedge clk) begin
    if (write) mem[bus_addr[11:0]] <= bus_data;
    else if (tb_we) mem[tb_wa] <= tb_wd;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [15:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_wa = a; tb_wd = d;
    @(posedge clk); #1;
    tb_we = 1'b0;
  endtask

  // Runs one copy; stall range, reset cycle and restart cycle are 0 when unused.
  task automatic run_copy(input logic [19:0] s, input logic [19:0] d, input logic [15:0] n,
                          input int stall_lo, input int stall_hi,
                          input int rst_cyc, input int restart_cyc);
    int nxt;
    done_cyc = 0; done_cnt = 0; busy_cnt = 0; overlap = 0;
    stall_strobes = 0; req_bad = 0; wr_cnt = 0;
    rd_q.delete();
    @(negedge clk);
    src_addr = s; dst_addr = d; len = n; start = 1'b1; grant = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    src_addr = 20'hABCDE; dst_addr = 20'h13579; len = 16'h0007;
    grant = !(1 >= stall_lo && 1 <= stall_hi);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (bus_req !== busy) req_bad++;
      if (read && write) overlap++;
      if (write) wr_cnt++;
      if (!grant && (read || write || bus_addr != 20'h0)) stall_strobes++;
      if (read) rd_q.push_back(bus_addr);
      if (rst_cyc != 0 && cyc == rst_cyc + 1) begin
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_read", {31'd0, read}, 32'd0);
        chk("rst_write", {31'd0, write}, 32'd0);
        chk("rst_addr", {12'd0, bus_addr}, 32'd0);
        chk("rst_data_z", {16'd0, bus_data}, {16'd0, z16});
      end
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (done_cyc != 0 && cyc == done_cyc + 1) break;
      @(posedge clk); #1;
      nxt = cyc + 1;
      start = (nxt == restart_cyc);
      if (nxt == restart_cyc) begin
        src_addr = 20'h00200; dst_addr = 20'h00500; len = 16'd1;
      end
      reset = (nxt == rst_cyc);
      grant = !(nxt >= stall_lo && nxt <= stall_hi);
    end
    reset = 1'b0; start = 1'b0; grant = 1'b1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; grant = 1'b1;
    src_addr = '0; dst_addr = '0; len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_req", {31'd0, bus_req}, 32'd0);
    chk("reset_rw", {30'd0, read, write}, 32'd0);
    chk("reset_addr", {12'd0, bus_addr}, 32'd0);
    chk("reset_data_z", {16'd0, bus_data}, {16'd0, z16});
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      poke(12'h100 + 12'(i), 16'hA001 + 16'(i));
      poke(12'hFFE + 12'(i), 16'hB001 + 16'(i));
      poke(12'h200 + 12'(i), 16'h0000);
      poke(12'h010 + 12'(i), 16'h0000);
      poke(12'h300 + 12'(i), 16'h0000);
      poke(12'h400 + 12'(i), 16'h0000);
      poke(12'h600 + 12'(i), 16'h0000);
    end
    poke(12'h500, 16'h0000);

    // Basic copy, grant tied high.
    run_copy(20'h00100, 20'h00200, 16'd4, 0, 0, 0, 0);
    chk("basic_done_cyc", done_cyc, 32'd9);
    chk("basic_done_once", done_cnt, 32'd1);
    chk("basic_busy_cnt", busy_cnt, 32'd8);
    chk("basic_req", req_bad, 32'd0);
    chk("basic_overlap", overlap, 32'd0);
    for (int i = 0; i < 4; i++)
      chk("basic_data", {16'd0, mem[12'h200 + 12'(i)]}, {16'd0, 16'hA001 + 16'(i)});

    // Zero length.
    run_copy(20'h00100, 20'h00200, 16'd0, 0, 0, 0, 0);
    chk("zero_done_cyc", done_cyc, 32'd1);
    chk("zero_busy", busy_cnt, 32'd0);
    chk("zero_reads", rd_q.size(), 32'd0);
    chk("zero_writes", wr_cnt, 32'd0);

    // Grant low in cycles 2-4 of a two-word copy.
    run_copy(20'h00100, 20'h00600, 16'd2, 2, 4, 0, 0);
    chk("stall_done_cyc", done_cyc, 32'd8);
    chk("stall_strobes", stall_strobes, 32'd0);
    chk("stall_busy_cnt", busy_cnt, 32'd7);
    chk("stall_req", req_bad, 32'd0);
    chk("stall_d0", {16'd0, mem[12'h600]}, 32'h0000A001);
    chk("stall_d1", {16'd0, mem[12'h601]}, 32'h0000A002);

    // Address wrap from the top of the space.
    run_copy(20'hFFFFE, 20'h00010, 16'd4, 0, 0, 0, 0);
    chk("wrap_nreads", rd_q.size(), 32'd4);
    if (rd_q.size() == 4) begin
      chk("wrap_rd0", {12'd0, rd_q[0]}, 32'h000FFFFE);
      chk("wrap_rd1", {12'd0, rd_q[1]}, 32'h000FFFFF);
      chk("wrap_rd2", {12'd0, rd_q[2]}, 32'h00000000);
      chk("wrap_rd3", {12'd0, rd_q[3]}, 32'h00000001);
    end
    chk("wrap_done_cyc", done_cyc, 32'd9);
    chk("wrap_d3", {16'd0, mem[12'h013]}, 32'h0000B004);

    // Reset during cycle 3 of a four-word copy.
    run_copy(20'h00100, 20'h00300, 16'd4, 0, 0, 3, 0);
    chk("abort_no_done", done_cnt, 32'd0);
    chk("abort_w0", {16'd0, mem[12'h300]}, 32'h0000A001);
    chk("abort_w1", {16'd0, mem[12'h301]}, 32'h00000000);

    // Second start during the copy must be ignored.
    run_copy(20'h00100, 20'h00400, 16'd4, 0, 0, 0, 2);
    chk("restart_done_cyc", done_cyc, 32'd9);
    chk("restart_busy_cnt", busy_cnt, 32'd8);
    chk("restart_d0", {16'd0, mem[12'h400]}, 32'h0000A001);
    chk("restart_d3", {16'd0, mem[12'h403]}, 32'h0000A004);
    chk("restart_other", {16'd0, mem[12'h500]}, 32'h00000000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_dma.md
# bus_dma

Bus initiator that copies a block of 16-bit words from one address range to another over the shared data bus. Memory-mapped responders on that bus read asynchronously and write on the clock edge. The block sits beside the CPU as a second bus master: it requests the bus, waits for a grant, then alternates read and write cycles until the programmed length has been moved. This offloads bulk copies (buffer moves, memory clears via self-overlap) from the datapath.

## Interface
- ADDR_W, 20: bus address width.
- DATA_W, 16: bus data width.
- LEN_W, 16: width of the transfer-length field, in words.

Ports:
- clk  in  1  single system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a copy; sampled only in IDLE.
- src_addr  in  ADDR_W  first source word address; latched on accepted start.
- dst_addr  in  ADDR_W  first destination word address; latched on accepted start.
- len  in  LEN_W  number of words to copy; latched on accepted start.
- busy  out  1  high while a copy is in progress (READ/WRITE states).
- done  out  1  one-cycle pulse when a copy completes.
- bus_req  out  1  bus request to the arbiter; high while busy.
- bus_grant  in  1  arbiter grant; bus outputs are active only while high.
- bus_addr  out  ADDR_W  bus address; 0 when neither read nor write is asserted.
- read  out  1  bus read strobe.
- write  out  1  bus write strobe.
- bus_data  inout  DATA_W  driven with the held word only while write is high, otherwise high-Z.

## Operation
- FSM states:
  - IDLE: waits for start.
  - READ: presents src + i.
  - WRITE: presents dst + i.
  - DONE: completes the copy.
- IDLE:
  - start = 1 with len ≠ 0: latch src, dst and len, clear the word index i, go to READ.
  - start = 1 with len = 0: go straight to DONE; no bus activity.
- READ:
  - read = bus_grant, bus_addr = src + i.
  - On an edge with bus_grant high: capture bus_data into the hold register, go to WRITE.
  - bus_grant low: stay in READ; no capture.
- WRITE:
  - write = bus_grant, bus_addr = dst + i, bus_data = hold register.
  - On an edge with bus_grant high: i increments. If i + 1 = len, go to DONE, else go to READ.
  - bus_grant low: stay in WRITE.
- DONE: done = 1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored. Input changes after latch have no effect.
- Address arithmetic is modulo 2^ADDR_W; src + i and dst + i wrap silently from 0xFFFFF to 0x00000.
- Read and write are never asserted in the same cycle.
- Overlapping ranges copy strictly in ascending order, word by word. No overlap correction.

## Timing
- Reset values: state IDLE; busy, done, bus_req, read and write all 0; bus_addr 0; bus_data high-Z; hold register, index and latched fields all 0.
- Reset mid-copy: abort on that edge. No done pulse, and no bus strobe in the following cycle. Words already written stay written.
- With bus_grant held high, start accepted at edge 0 gives:
  - word k read in cycle 2k + 1 and written in cycle 2k + 2;
  - done high in cycle 2N + 1;
  - busy and bus_req high in cycles 1 through 2N.
- len = 0: done in cycle 1; busy never asserted.
- Each cycle with bus_grant low while busy adds exactly one cycle of latency. The strobe and address resume unchanged.
- The read data path is combinational from the responder; the hold register captures at the end of the READ cycle.

## Structure
- Shared package bus_pkg holds:
  - ADDR_W and DATA_W, the bus-wide constants;
  - the dma_state_t enum (IDLE, READ, WRITE, DONE).
- Single flat module. No sub-module is warranted; the tri-state driver is one continuous assignment.

## Test plan
- Basic copy: memory words 0x0100–0x0103 = 0xA001..0xA004; start with src 0x00100, dst 0x00200, len 4, grant tied high -> words 0x0200–0x0203 equal 0xA001..0xA004; done at cycle 9; busy high for 8 cycles.
- Zero length: len 0 -> done at cycle 1; read and write never asserted; busy stays 0.
- Grant stall: grant low for cycles 2–4 during a len-2 copy -> strobes are held off while grant is low; done at cycle 8; destination data correct.
- Wrap-around: src 0xFFFFE, dst 0x00010, len 4 -> reads from 0xFFFFE, 0xFFFFF, 0x00000, 0x00001 in that order.
- Reset mid-copy: reset in cycle 3 of a len-4 copy -> next cycle is IDLE with strobes 0 and bus_data high-Z; no done pulse; only word 0 copied.
- Start while busy: a second start in cycle 2 with different fields -> ignored; the first copy completes unchanged.
